// File: rtl/ctrl_mat_mult_p_pkg.sv
// Shared definitions for the matrix-multiply controller: FSM state
// encoding, legal MAC latency range and a width helper.
package mat_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mm_state_e;

  localparam int MAC_LAT_MIN = 1;
  localparam int MAC_LAT_MAX = 8;

  // Drain counter must hold values up to MAC_LAT_MAX-1.
  localparam int DRAIN_W = $clog2(MAC_LAT_MAX + 1);

  // Bit width able to index n items; never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_mat_mult_p_if.sv
// Command/status bundle between a requester and ctrl_mat_mult_p.
// stall_count is present only when CTRL_MM_PERF_EN is defined.
interface ctrl_mat_mult_p_if #(
  parameter int M   = 8,
  parameter int N   = 8,
  parameter int K   = 8,
  parameter int CCW = 16
);
  import mat_mult_pkg::*;

  localparam int AW = cw(M * K);
  localparam int BW = cw(K * N);
  localparam int WW = cw(M * N);

  logic           start;
  logic           abort;
  logic           stall;
  logic           load;
  logic           mac_en;
  logic           mac_clr;
  logic [AW-1:0]  a_addr;
  logic [BW-1:0]  b_addr;
  logic           wr_en;
  logic [WW-1:0]  wr_addr;
  logic           busy;
  logic           done;
  logic [CCW-1:0] clock_count;
`ifdef CTRL_MM_PERF_EN
  logic [CCW-1:0] stall_count;
`endif

  modport master (
    output start, abort, stall,
    input  load, mac_en, mac_clr, a_addr, b_addr, wr_en, wr_addr,
           busy, done, clock_count
`ifdef CTRL_MM_PERF_EN
    , input stall_count
`endif
  );

  modport slave (
    input  start, abort, stall,
    output load, mac_en, mac_clr, a_addr, b_addr, wr_en, wr_addr,
           busy, done, clock_count
`ifdef CTRL_MM_PERF_EN
    , output stall_count
`endif
  );

endinterface

// File: rtl/ctrl_mat_mult_p_index_gen.sv
// Row/col/k iteration counters for the matrix-multiply controller.
// k runs fastest, then col, then row; each wraps to 0 and carries.
module mm_index_gen
  import mat_mult_pkg::*;
#(
  parameter int M  = 8,
  parameter int N  = 8,
  parameter int K  = 8,
  parameter int RW = cw(M),
  parameter int CW = cw(N),
  parameter int KW = cw(K)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic [KW-1:0] o_k,
  output logic          o_last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(N - 1);
  localparam logic [KW-1:0] K_MAX   = KW'(K - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [KW-1:0] r_k;

  // Step the (row,col,k) triple once per advance; clear returns to origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else if (i_adv) begin
      if (r_k == K_MAX) begin
        r_k <= '0;
        if (r_col == COL_MAX) begin
          r_col <= '0;
          if (r_row == ROW_MAX) begin
            r_row <= '0;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_k    = r_k;
  assign o_last = (r_row == ROW_MAX) && (r_col == COL_MAX) && (r_k == K_MAX);

endmodule

// File: rtl/ctrl_mat_mult_p.sv
// Matrix-multiply sequencing controller: walks (row,col,k), drives operand
// fetch and MAC control, and emits result writes MAC_LAT cycles after the
// last k of each element. Optional macro CTRL_MM_PERF_EN adds stall_count.
module ctrl_mat_mult_p
  import mat_mult_pkg::*;
#(
  parameter int M       = 8,
  parameter int N       = 8,
  parameter int K       = 8,
  parameter int MAC_LAT = 1,
  parameter int CCW     = 16
) (
  input logic               clk,
  input logic               reset_n,
  ctrl_mat_mult_p_if.slave  bus
);

  localparam int RW = cw(M);
  localparam int CW = cw(N);
  localparam int KW = cw(K);
  localparam int AW = cw(M * K);
  localparam int BW = cw(K * N);
  localparam int WW = cw(M * N);

  localparam logic [KW-1:0]      K_MAX     = KW'(K - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(MAC_LAT - 1);
  localparam logic [CCW-1:0]     CNT_MAX   = {CCW{1'b1}};

  mm_state_e          r_state;
  logic               r_busy;
  logic               r_done;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [CCW-1:0]     r_clk_cnt;
  logic               r_pipe_vld  [MAC_LAT];
  logic [WW-1:0]      r_pipe_addr [MAC_LAT];

  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [KW-1:0] w_k;
  logic          w_last;
  logic          w_active;
  logic          w_start_run;
  logic          w_issue;
  logic          w_push;
  logic          w_wr;
  logic [WW-1:0] w_push_addr;

  // A run occupies RUN and DRAIN; abort and stall both suppress issue.
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_start_run = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_issue     = (r_state == ST_RUN) && !bus.stall && !bus.abort;
  assign w_push      = w_issue && (w_k == K_MAX);
  assign w_push_addr = WW'(w_row) * WW'(N) + WW'(w_col);
  assign w_wr        = r_pipe_vld[MAC_LAT-1] && !bus.stall && !bus.abort;

  mm_index_gen #(
    .M  (M),
    .N  (N),
    .K  (K),
    .RW (RW),
    .CW (CW),
    .KW (KW)
  ) u_index_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_start_run || bus.abort),
    .i_adv   (w_issue),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_k     (w_k),
    .o_last  (w_last)
  );

  // Run-sequencing FSM with registered busy/done flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain_cnt <= '0;
    end else if (bus.abort && (r_state != ST_IDLE)) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!bus.stall && w_last) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (!bus.stall) begin
            if (r_drain_cnt == DRAIN_END) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Level start held high keeps us here; no automatic restart.
          if (!bus.start) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back pipeline: carries the C address MAC_LAT unstalled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_addr[i] <= '0;
      end
    end else if (bus.abort) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        r_pipe_vld[i]  <= 1'b0;
        r_pipe_addr[i] <= '0;
      end
    end else if (!bus.stall) begin
      r_pipe_vld[0]  <= w_push;
      r_pipe_addr[0] <= w_push_addr;
      for (int i = 1; i < MAC_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  // Saturating run-length counter, stalled cycles included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt <= '0;
    end else if (w_start_run) begin
      r_clk_cnt <= '0;
    end else if (w_active && (r_clk_cnt != CNT_MAX)) begin
      r_clk_cnt <= r_clk_cnt + CCW'(1);
    end
  end

`ifdef CTRL_MM_PERF_EN
  logic [CCW-1:0] r_stall_cnt;

  // Saturating count of stalled run cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_run) begin
      r_stall_cnt <= '0;
    end else if (w_active && bus.stall && !bus.abort && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CCW'(1);
    end
  end

  assign bus.stall_count = r_stall_cnt;
`endif

  assign bus.load        = w_issue;
  assign bus.mac_en      = w_issue;
  assign bus.mac_clr     = w_issue && (w_k == {KW{1'b0}});
  assign bus.a_addr      = AW'(w_row) * AW'(K) + AW'(w_k);
  assign bus.b_addr      = BW'(w_k) * BW'(N) + BW'(w_col);
  assign bus.wr_en       = w_wr;
  assign bus.wr_addr     = r_pipe_addr[MAC_LAT-1];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.clock_count = r_clk_cnt;

endmodule

// File: tb/tb_ctrl_mat_mult_p.sv
// Self-checking bench for ctrl_mat_mult_p: two configurations, random and
// directed stalls, abort, start held through DONE, and asynchronous reset.
`timescale 1ns/1ps
module tb_ctrl_mat_mult_p;

  localparam int AM = 8, AN = 8, AK = 8, AL = 1, ACCW = 16;
  localparam int BM = 2, BN = 3, BK = 4, BL = 3, BCCW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  ctrl_mat_mult_p_if #(.M(AM), .N(AN), .K(AK), .CCW(ACCW)) ifa ();
  ctrl_mat_mult_p_if #(.M(BM), .N(BN), .K(BK), .CCW(BCCW)) ifb ();

  assign ifa.start = start;
  assign ifa.abort = abort;
  assign ifa.stall = stall;
  assign ifb.start = start;
  assign ifb.abort = abort;
  assign ifb.stall = stall;

  ctrl_mat_mult_p #(.M(AM), .N(AN), .K(AK), .MAC_LAT(AL), .CCW(ACCW)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa.slave)
  );

  ctrl_mat_mult_p #(.M(BM), .N(BN), .K(BK), .MAC_LAT(BL), .CCW(BCCW)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb.slave)
  );

  // Selected configuration and its parameters for the reference model.
  int sel = 0;
  int pm = AM, pn = AN, pk = AK, pl = AL, pccw = ACCW;

  logic [31:0] o_load, o_en, o_clr, o_aa, o_ba, o_wr, o_wa, o_busy, o_done, o_cc;
`ifdef CTRL_MM_PERF_EN
  logic [31:0] o_sc;
`endif

  always_comb begin
    if (sel == 0) begin
      o_load = 32'(ifa.load);   o_en = 32'(ifa.mac_en); o_clr = 32'(ifa.mac_clr);
      o_aa   = 32'(ifa.a_addr); o_ba = 32'(ifa.b_addr); o_wr  = 32'(ifa.wr_en);
      o_wa   = 32'(ifa.wr_addr); o_busy = 32'(ifa.busy); o_done = 32'(ifa.done);
      o_cc   = 32'(ifa.clock_count);
`ifdef CTRL_MM_PERF_EN
      o_sc   = 32'(ifa.stall_count);
`endif
    end else begin
      o_load = 32'(ifb.load);   o_en = 32'(ifb.mac_en); o_clr = 32'(ifb.mac_clr);
      o_aa   = 32'(ifb.a_addr); o_ba = 32'(ifb.b_addr); o_wr  = 32'(ifb.wr_en);
      o_wa   = 32'(ifb.wr_addr); o_busy = 32'(ifb.busy); o_done = 32'(ifb.done);
      o_cc   = 32'(ifb.clock_count);
`ifdef CTRL_MM_PERF_EN
      o_sc   = 32'(ifb.stall_count);
`endif
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic set_sel(input int s);
    sel = s;
    if (s == 0) begin
      pm = AM; pn = AN; pk = AK; pl = AL; pccw = ACCW;
    end else begin
      pm = BM; pn = BN; pk = BK; pl = BL; pccw = BCCW;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"}, o_load, 0);   chk({tag, "_mac_en"}, o_en, 0);
    chk({tag, "_mac_clr"}, o_clr, 0); chk({tag, "_a_addr"}, o_aa, 0);
    chk({tag, "_b_addr"}, o_ba, 0);   chk({tag, "_wr_en"}, o_wr, 0);
    chk({tag, "_wr_addr"}, o_wa, 0);  chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);   chk({tag, "_clock_count"}, o_cc, 0);
`ifdef CTRL_MM_PERF_EN
    chk({tag, "_stall_count"}, o_sc, 0);
`endif
  endtask

  // One run of the selected configuration against the reference model.
  // Issue n maps to row=n/(N*K), col=(n/K)%N, k=n%K; a write for element
  // row*N+col is due MAC_LAT unstalled cycles after its k=K-1 issue.
  task automatic run_one(input int stall_pct, input int burst_at,
                         input int abort_at, input bit hold_start);
    int total, sat, n, tick, cyc, nstall, loads, writes, burst_left;
    int row, col, kk;
    int due_t[$];
    int due_a[$];
    bit burst_used, finished, aborted, exp_load, exp_wr;
    total = pm * pn * pk;
    sat = (1 << pccw) - 1;
    n = 0; tick = 0; cyc = 0; nstall = 0; loads = 0; writes = 0; burst_left = 0;
    burst_used = 1'b0; finished = 1'b0; aborted = 1'b0;

    @(posedge clk); #1; abort = 1'b1; stall = 1'b0; start = 1'b0;
    @(posedge clk); #1; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;

    while (!finished && !aborted && cyc < 3000) begin
      cyc++;
      stall = 1'b0;
      abort = 1'b0;
      if (n == abort_at) begin
        abort = 1'b1;
      end else if (burst_left > 0) begin
        stall = 1'b1;
        burst_left--;
      end else if (!burst_used && n == burst_at) begin
        burst_used = 1'b1;
        stall = 1'b1;
        burst_left = 9;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        stall = 1'b1;
      end
      @(negedge clk);
      chk("run_busy", o_busy, 1);
      chk("run_done", o_done, 0);
      chk("run_clock_count", o_cc, imin(cyc - 1, sat));
      if (abort) begin
        chk("abort_cycle_wr_en", o_wr, 0);
        aborted = 1'b1;
      end else begin
        exp_load = !stall && (n < total);
        chk("load", o_load, 32'(exp_load));
        chk("mac_en", o_en, 32'(exp_load));
        if (o_load === 32'd1) loads++;
        if (exp_load) begin
          row = n / (pn * pk);
          col = (n / pk) % pn;
          kk  = n % pk;
          chk("a_addr", o_aa, row * pk + kk);
          chk("b_addr", o_ba, kk * pn + col);
          chk("mac_clr", o_clr, 32'(kk == 0));
          if (kk == pk - 1) begin
            due_t.push_back(tick + pl);
            due_a.push_back(row * pn + col);
          end
          n++;
        end
        exp_wr = !stall && (due_t.size() > 0) && (due_t[0] == tick);
        chk("wr_en", o_wr, 32'(exp_wr));
        if (o_wr === 32'd1) writes++;
        if (exp_wr) begin
          chk("wr_addr", o_wa, due_a[0]);
          void'(due_t.pop_front());
          void'(due_a.pop_front());
        end
        if (stall) nstall++;
        else tick++;
        finished = (tick == total + pl);
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    abort = 1'b0;

    if (aborted) begin
      repeat (6) begin
        @(negedge clk);
        chk("post_abort_busy", o_busy, 0);
        chk("post_abort_done", o_done, 0);
        chk("post_abort_wr_en", o_wr, 0);
        chk("post_abort_load", o_load, 0);
        @(posedge clk); #1;
      end
    end else begin
      chk("run_timeout", 32'(finished), 1);
      chk("loads_total", loads, total);
      chk("writes_total", writes, pm * pn);
      chk("writes_pending", due_t.size(), 0);
      @(negedge clk);
      chk("done_set", o_done, 1);
      chk("done_busy", o_busy, 0);
      chk("final_clock_count", o_cc, imin(cyc, sat));
`ifdef CTRL_MM_PERF_EN
      chk("final_stall_count", o_sc, imin(nstall, sat));
`endif
      if (hold_start) begin
        repeat (3) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("done_hold", o_done, 1);
          chk("done_hold_load", o_load, 0);
        end
        start = 1'b0;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_done", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_clock_count_hold", o_cc, imin(cyc, sat));
    end
  endtask

  // Assert reset asynchronously while the small configuration is draining.
  task automatic reset_mid_drain();
    set_sel(1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    chk("pre_reset_busy", o_busy, 1);
    chk("pre_reset_clock_count", o_cc, 25);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    chk_all_zero("held_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_reset_busy", o_busy, 0);
    chk("after_reset_done", o_done, 0);
  endtask

  initial begin
    set_sel(0);
    #3;
    chk_all_zero("reset_a");
    set_sel(1);
    #1;
    chk_all_zero("reset_b");
    @(negedge clk);
    reset_n = 1'b1;

    set_sel(0); run_one(0, -1, -1, 1'b0);     // full default run
    set_sel(1); run_one(0, -1, -1, 1'b0);     // 2x3x4, latency 3
    set_sel(0); run_one(0, 200, -1, 1'b0);    // 10-cycle stall burst mid-run
    set_sel(0); run_one(0, -1, 100, 1'b0);    // abort at issue 100
    set_sel(0); run_one(15, -1, -1, 1'b0);    // clean run with random stalls
    set_sel(1); run_one(50, -1, -1, 1'b1);    // start held through DONE, counter saturates
    set_sel(1); run_one(20, -1, -1, 1'b0);    // restart from 0 after DONE
    reset_mid_drain();
    set_sel(1); run_one(0, -1, -1, 1'b0);     // clean run after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
